multicycle_ctrl: RTL

Control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake. It drives every datapath select and enable, including the immediate-extension mode (sign vs zero) used by the 16→32 extender. It also counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/write-back,
// drives all datapath selects and enables, and counts retired instructions.
module multicycle_ctrl #(
    parameter logic [31:0] CNT_RESET_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        iord_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [1:0]  pc_src_o,
    output logic        ext_sign_o,
    output logic [3:0]  state_o,
    output logic        instr_done_o,
    output logic        illegal_o,
    output logic [31:0] instr_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXE_R    = 4'd3,
        EXE_I    = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        WB_R     = 4'd11,
        WB_I     = 4'd12
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] instr_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            instr_cnt_reg <= CNT_RESET_VAL;
        end else begin
            state_reg <= state_next;
            if (instr_done_o)
                instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
    end

    // Immediates of arithmetic ops are sign-extended, logical ops zero-extended.
    logic imm_signed;
    assign imm_signed = (opcode_i == OP_ADDI) || (opcode_i == OP_SLTI);

    always_comb begin
        state_next   = state_reg;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = ALU_ADD;
        pc_src_o     = 2'b00;
        ext_sign_o   = 1'b0;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;

        unique case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i)
                    state_next = DECODE;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                ext_sign_o  = 1'b1;
                unique case (opcode_i)
                    OP_RTYPE:                         state_next = EXE_R;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_next = EXE_I;
                    OP_LW, OP_SW:                     state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_next = BRANCH;
                    OP_J:                             state_next = JUMP;
                    default: begin
                        state_next = FETCH;
                        illegal_o  = 1'b1;
                    end
                endcase
            end
            EXE_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
                state_next  = WB_R;
            end
            WB_R: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
                state_next   = FETCH;
            end
            EXE_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                ext_sign_o  = imm_signed;
                unique case (opcode_i)
                    OP_SLTI: alu_op_o = ALU_SLT;
                    OP_ORI:  alu_op_o = ALU_OR;
                    OP_LUI:  alu_op_o = ALU_LUI;
                    default: alu_op_o = ALU_ADD;
                endcase
                state_next = WB_I;
            end
            WB_I: begin
                reg_write_o  = 1'b1;
                ext_sign_o   = imm_signed;
                instr_done_o = 1'b1;
                state_next   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                ext_sign_o  = 1'b1;
                state_next  = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i)
                    state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
                state_next   = FETCH;
            end
            MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) begin
                    instr_done_o = 1'b1;
                    state_next   = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = ALU_SUB;
                pc_src_o     = 2'b01;
                pc_write_o   = (opcode_i == OP_BNE) ? !zero_i : zero_i;
                instr_done_o = 1'b1;
                state_next   = FETCH;
            end
            JUMP: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
                state_next   = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_o     = state_reg;
    assign instr_cnt_o = instr_cnt_reg;

endmodule
